// File: rtl/mmio_stream_mailbox_if.sv
// Bus and stream signals of the MMIO stream mailbox.
// slave is the mailbox side; master is the CPU plus stream endpoints.
interface mmio_stream_mailbox_if;
  logic        iReadEnable;
  logic        iWriteEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic [31:0] oReadData;
  logic        oTxValid;
  logic [31:0] oTxData;
  logic        iTxReady;
  logic        iRxValid;
  logic [31:0] iRxData;
  logic        oRxReady;
  logic        oIRQ;

  modport slave (
    input  iReadEnable, iWriteEnable, iByteEnable, iAddress, iWriteData,
    input  iTxReady, iRxValid, iRxData,
    output oReadData, oTxValid, oTxData, oRxReady, oIRQ
  );

  modport master (
    output iReadEnable, iWriteEnable, iByteEnable, iAddress, iWriteData,
    output iTxReady, iRxValid, iRxData,
    input  oReadData, oTxValid, oTxData, oRxReady, oIRQ
  );
endinterface

// File: rtl/mmio_stream_mailbox.sv
// MMIO responder bridging CPU loads/stores to a TX and an RX valid/ready stream
// through two FIFOs, with status/control/threshold registers and an IRQ.
module mmio_stream_mailbox #(
  parameter logic [31:0] BASE_ADDR = 32'hFF20_0000,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = 4
) (
  input logic                  iCLK,
  input logic                  iRST,
  mmio_stream_mailbox_if.slave bus
);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   txMem [DEPTH];
  logic [AW-1:0] txRd, txWr;
  logic [CW-1:0] txCount;
  logic [31:0]   rxMem [DEPTH];
  logic [AW-1:0] rxRd, rxWr;
  logic [CW-1:0] rxCount;
  logic [CW-1:0] thresh;
  logic          irqEn, txOver, rxUnder, beErr, irq;

  logic          hit;
  logic [1:0]    offset;
  logic          dataRd, dataWr, ctrlWr, threshWr, fullWord;
  logic          txFull, txEmpty, rxFull, rxEmpty;
  logic          txPush, txPop, rxPush, rxPop;
  logic          txFlush, rxFlush, stickyClr;
  logic          setTxOver, setRxUnder, setBeErr;
  logic [31:0]   status, readData;
  logic          unusedBits;

  assign hit    = (bus.iAddress[31:4] == BASE_ADDR[31:4]);
  assign offset = bus.iAddress[3:2];

  assign txFull  = (txCount == FULL_COUNT);
  assign txEmpty = (txCount == '0);
  assign rxFull  = (rxCount == FULL_COUNT);
  assign rxEmpty = (rxCount == '0);

  // Decode of bus strobes into FIFO and register events; all judged on pre-edge state.
  always_comb begin
    dataRd     = hit & bus.iReadEnable  & (offset == 2'd0);
    dataWr     = hit & bus.iWriteEnable & (offset == 2'd0);
    ctrlWr     = hit & bus.iWriteEnable & (offset == 2'd2);
    threshWr   = hit & bus.iWriteEnable & (offset == 2'd3) & bus.iByteEnable[0];
    fullWord   = (bus.iByteEnable == 4'hF);
    txPush     = dataWr & fullWord & ~txFull;
    setTxOver  = dataWr & fullWord & txFull;
    setBeErr   = dataWr & ~fullWord;
    rxPop      = dataRd & ~rxEmpty;
    setRxUnder = dataRd & rxEmpty;
    txPop      = ~txEmpty & bus.iTxReady;
    rxPush     = bus.iRxValid & ~rxFull;
    txFlush    = ctrlWr & bus.iByteEnable[0] & bus.iWriteData[0];
    rxFlush    = ctrlWr & bus.iByteEnable[0] & bus.iWriteData[1];
    stickyClr  = ctrlWr & bus.iByteEnable[0] & bus.iWriteData[2];
  end

  always_comb begin
    status          = '0;
    status[CW-1:0]  = txCount;
    status[8 +: CW] = rxCount;
    status[16]      = txFull;
    status[17]      = txEmpty;
    status[18]      = rxFull;
    status[19]      = rxEmpty;
    status[24]      = txOver;
    status[26]      = rxUnder;
    status[27]      = beErr;
  end

  // Combinational read mux; zero unless a hit read is in progress.
  always_comb begin
    readData = '0;
    if (hit && bus.iReadEnable) begin
      case (offset)
        2'd0:    readData = rxEmpty ? 32'h0 : rxMem[rxRd];
        2'd1:    readData = status;
        2'd2:    readData = {23'b0, irqEn, 8'b0};
        default: readData = 32'(thresh);
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      txRd    <= '0;
      txWr    <= '0;
      txCount <= '0;
      rxRd    <= '0;
      rxWr    <= '0;
      rxCount <= '0;
      thresh  <= CW'(1);
      irqEn   <= 1'b0;
      txOver  <= 1'b0;
      rxUnder <= 1'b0;
      beErr   <= 1'b0;
      irq     <= 1'b0;
    end else begin
      // Flush overrides any push or pop in the same cycle.
      if (txFlush) begin
        txRd    <= '0;
        txWr    <= '0;
        txCount <= '0;
      end else begin
        if (txPush) txWr <= txWr + AW'(1);
        if (txPop)  txRd <= txRd + AW'(1);
        txCount <= txCount + CW'(txPush) - CW'(txPop);
      end
      if (rxFlush) begin
        rxRd    <= '0;
        rxWr    <= '0;
        rxCount <= '0;
      end else begin
        if (rxPush) rxWr <= rxWr + AW'(1);
        if (rxPop)  rxRd <= rxRd + AW'(1);
        rxCount <= rxCount + CW'(rxPush) - CW'(rxPop);
      end
      txOver  <= (txOver  & ~stickyClr) | setTxOver;
      rxUnder <= (rxUnder & ~stickyClr) | setRxUnder;
      beErr   <= (beErr   & ~stickyClr) | setBeErr;
      if (ctrlWr && bus.iByteEnable[1]) irqEn <= bus.iWriteData[8];
      if (threshWr) thresh <= bus.iWriteData[CW-1:0];
      irq <= irqEn & (((rxCount >= thresh) & (rxCount != '0)) | txOver | rxUnder | beErr);
    end
  end

  // FIFO storage needs no reset; pointers define validity.
  always_ff @(posedge iCLK) begin
    if (txPush) txMem[txWr] <= bus.iWriteData;
    if (rxPush) rxMem[rxWr] <= bus.iRxData;
  end

  assign bus.oReadData = readData;
  assign bus.oTxValid  = ~txEmpty;
  assign bus.oTxData   = txMem[txRd];
  assign bus.oRxReady  = ~rxFull;
  assign bus.oIRQ      = irq;

  assign unusedBits = ^{bus.iAddress[1:0], bus.iByteEnable[3:2], bus.iWriteData};
endmodule

// File: tb/tb_mmio_stream_mailbox.sv
// Bench for mmio_stream_mailbox: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mmio_stream_mailbox;
  localparam logic [31:0] BASE = 32'hFF20_0000;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic iCLK = 1'b0;
  logic iRST;
  int   tests = 0;
  int   fails = 0;
  bit   modelValid = 1'b0;

  mmio_stream_mailbox_if mbx();

  mmio_stream_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .AW(AW)) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (mbx)
  );

  always #5 iCLK = ~iCLK;

  // Reference model state
  logic [31:0] txQ[$];
  logic [31:0] rxQ[$];
  bit txOver, rxUnder, beErr, irqEn, expIrq;
  int thresh;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelStatus();
    int s;
    s = txQ.size() + rxQ.size() * 256;
    if (txQ.size() == DEPTH) s += 1 << 16;
    if (txQ.size() == 0)     s += 1 << 17;
    if (rxQ.size() == DEPTH) s += 1 << 18;
    if (rxQ.size() == 0)     s += 1 << 19;
    if (txOver)  s += 1 << 24;
    if (rxUnder) s += 1 << 26;
    if (beErr)   s += 1 << 27;
    return 32'(s);
  endfunction

  function automatic logic [31:0] modelRead();
    if (!mbx.iReadEnable || mbx.iAddress[31:4] != BASE[31:4]) return 32'h0;
    case (mbx.iAddress[3:2])
      2'd0:    return (rxQ.size() != 0) ? rxQ[0] : 32'h0;
      2'd1:    return modelStatus();
      2'd2:    return irqEn ? 32'h100 : 32'h0;
      default: return 32'(thresh);
    endcase
  endfunction

  // Model update at each active edge from the pre-edge model state and inputs.
  always @(posedge iCLK) begin : model
    bit hitM, rd, wr, txWasFull, rxWasFull, doTxPop, doRxPush, doTxPush, doRxPop;
    bit setO, setU, setB, fTx, fRx, clr, nIrq;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wd;
    if (iRST) begin
      txQ.delete();
      rxQ.delete();
      txOver = 0; rxUnder = 0; beErr = 0; irqEn = 0; expIrq = 0;
      thresh = 1;
      modelValid = 1'b1;
    end else if (modelValid) begin
      nIrq = irqEn && ((rxQ.size() >= thresh && rxQ.size() != 0) || txOver || rxUnder || beErr);
      hitM = (mbx.iAddress[31:4] == BASE[31:4]);
      off  = mbx.iAddress[3:2];
      be   = mbx.iByteEnable;
      wd   = mbx.iWriteData;
      rd   = hitM && mbx.iReadEnable;
      wr   = hitM && mbx.iWriteEnable;
      txWasFull = (txQ.size() == DEPTH);
      rxWasFull = (rxQ.size() == DEPTH);
      doTxPop   = (txQ.size() != 0) && mbx.iTxReady;
      doRxPush  = mbx.iRxValid && !rxWasFull;
      doTxPush = 0; doRxPop = 0; setO = 0; setU = 0; setB = 0; fTx = 0; fRx = 0; clr = 0;
      if (rd && off == 2'd0) begin
        if (rxQ.size() == 0) setU = 1; else doRxPop = 1;
      end
      if (wr && off == 2'd0) begin
        if (be == 4'hF) begin
          if (txWasFull) setO = 1; else doTxPush = 1;
        end else setB = 1;
      end
      if (wr && off == 2'd2) begin
        if (be[0]) begin fTx = wd[0]; fRx = wd[1]; clr = wd[2]; end
        if (be[1]) irqEn = wd[8];
      end
      if (wr && off == 2'd3 && be[0]) thresh = int'(wd % (2 * DEPTH));
      if (doTxPop)  void'(txQ.pop_front());
      if (doTxPush) txQ.push_back(wd);
      if (fTx)      txQ.delete();
      if (doRxPop)  void'(rxQ.pop_front());
      if (doRxPush) rxQ.push_back(mbx.iRxData);
      if (fRx)      rxQ.delete();
      if (clr) begin txOver = 0; rxUnder = 0; beErr = 0; end
      txOver  = txOver  | setO;
      rxUnder = rxUnder | setU;
      beErr   = beErr   | setB;
      expIrq  = nIrq;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge iCLK) begin
    if (modelValid) begin
      chk("readData", mbx.oReadData, modelRead());
      chk("txValid", 32'(mbx.oTxValid), 32'(txQ.size() != 0));
      if (txQ.size() != 0) chk("txData", mbx.oTxData, txQ[0]);
      chk("rxReady", 32'(mbx.oRxReady), 32'(txQ.size() >= 0 && rxQ.size() < DEPTH));
      chk("irq", 32'(mbx.oIRQ), 32'(expIrq));
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle();
    mbx.iReadEnable  = 1'b0;
    mbx.iWriteEnable = 1'b0;
    mbx.iByteEnable  = 4'h0;
    mbx.iAddress     = 32'h0;
    mbx.iWriteData   = 32'h0;
  endtask

  task automatic busWrite(input logic [1:0] off, input logic [3:0] be, input logic [31:0] d);
    mbx.iReadEnable  = 1'b0;
    mbx.iWriteEnable = 1'b1;
    mbx.iByteEnable  = be;
    mbx.iAddress     = BASE + (32'(off) << 2);
    mbx.iWriteData   = d;
    tick();
    idle();
  endtask

  task automatic busReadChk(input string name, input logic [1:0] off, input logic [31:0] exp);
    mbx.iReadEnable  = 1'b1;
    mbx.iWriteEnable = 1'b0;
    mbx.iByteEnable  = 4'hF;
    mbx.iAddress     = BASE + (32'(off) << 2);
    #1;
    chk(name, mbx.oReadData, exp);
    tick();
    idle();
  endtask

  initial begin
    idle();
    mbx.iTxReady = 1'b0;
    mbx.iRxValid = 1'b0;
    mbx.iRxData  = 32'h0;
    iRST = 1'b1;
    tick();
    tick();
    iRST = 1'b0;
    #1;
    chk("reset rxReady", 32'(mbx.oRxReady), 32'h1);
    chk("reset txValid", 32'(mbx.oTxValid), 32'h0);
    chk("reset irq", 32'(mbx.oIRQ), 32'h0);
    busReadChk("reset status", 2'd1, 32'h000A_0000);
    busReadChk("reset thresh", 2'd3, 32'h1);

    // TX fill to full, overflow, then drain in order
    for (int i = 0; i < 16; i++) busWrite(2'd0, 4'hF, 32'(i));
    busReadChk("tx full status", 2'd1, 32'h0009_0010);
    busWrite(2'd0, 4'hF, 32'd16);
    busReadChk("txover status", 2'd1, 32'h0109_0010);
    mbx.iTxReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("tx order", mbx.oTxData, 32'(i));
      tick();
    end
    chk("tx drained", 32'(mbx.oTxValid), 32'h0);
    mbx.iTxReady = 1'b0;
    busWrite(2'd2, 4'h1, 32'h4);

    // RX threshold IRQ and underflow
    busWrite(2'd3, 4'h1, 32'h2);
    busWrite(2'd2, 4'h2, 32'h100);
    mbx.iRxValid = 1'b1;
    mbx.iRxData  = 32'hAAAA_0001;
    tick();
    mbx.iRxData  = 32'hBBBB_0002;
    tick();
    mbx.iRxData  = 32'hCCCC_0003;
    #1;
    chk("irq not yet", 32'(mbx.oIRQ), 32'h0);
    tick();
    mbx.iRxValid = 1'b0;
    #1;
    chk("irq raised", 32'(mbx.oIRQ), 32'h1);
    busReadChk("rx A", 2'd0, 32'hAAAA_0001);
    busReadChk("rx B", 2'd0, 32'hBBBB_0002);
    busReadChk("rx C", 2'd0, 32'hCCCC_0003);
    busReadChk("rx empty read", 2'd0, 32'h0);
    busReadChk("rxunder status", 2'd1, 32'h040A_0000);
    chk("irq on rxunder", 32'(mbx.oIRQ), 32'h1);
    busReadChk("control readback", 2'd2, 32'h100);
    busWrite(2'd2, 4'h1, 32'h4);
    busWrite(2'd2, 4'h2, 32'h0);

    // Byte store error and sticky clear
    busWrite(2'd0, 4'h1, 32'hDEAD_BEEF);
    busReadChk("beerr status", 2'd1, 32'h080A_0000);
    busWrite(2'd2, 4'h1, 32'h4);
    busReadChk("cleared status", 2'd1, 32'h000A_0000);

    // Write to full TX concurrent with stream pop is still dropped
    for (int i = 0; i < 16; i++) busWrite(2'd0, 4'hF, 32'h100 + 32'(i));
    mbx.iTxReady = 1'b1;
    busWrite(2'd0, 4'hF, 32'h77);
    mbx.iTxReady = 1'b0;
    busReadChk("full write+pop status", 2'd1, 32'h0108_000F);
    busWrite(2'd2, 4'h1, 32'h5);
    busReadChk("tx flush status", 2'd1, 32'h000A_0000);

    // RX flush concurrent with a stream push
    mbx.iRxValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mbx.iRxData = 32'h500 + 32'(i);
      tick();
    end
    mbx.iRxValid = 1'b0;
    busReadChk("rx five status", 2'd1, 32'h0002_0500);
    mbx.iRxValid = 1'b1;
    mbx.iRxData  = 32'h5FF;
    busWrite(2'd2, 4'h1, 32'h2);
    mbx.iRxValid = 1'b0;
    busReadChk("rx flush status", 2'd1, 32'h000A_0000);

    // Reset in the middle of traffic
    busWrite(2'd2, 4'h2, 32'h100);
    mbx.iRxValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mbx.iRxData = 32'h900 + 32'(i);
      busWrite(2'd0, 4'hF, 32'h800 + 32'(i));
    end
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    mbx.iRxValid = 1'b0;
    busReadChk("post reset status", 2'd1, 32'h000A_0000);
    chk("post reset irq", 32'(mbx.oIRQ), 32'h0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int k, s;
      logic [1:0] off;
      k = $urandom_range(0, 9);
      s = $urandom_range(0, 19);
      off = (s < 10) ? 2'd0 : (s < 14) ? 2'd1 : (s < 17) ? 2'd2 : 2'd3;
      mbx.iReadEnable  = (k < 5) || (k == 9);
      mbx.iWriteEnable = (k >= 4);
      mbx.iAddress     = ((s == 19) ? BASE + 32'h100 : BASE) + (32'(off) << 2)
                         + 32'($urandom_range(0, 3));
      case (off)
        2'd0: begin
          mbx.iWriteData  = $urandom();
          mbx.iByteEnable = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        end
        2'd2: begin
          mbx.iByteEnable = 4'($urandom_range(0, 3));
          mbx.iWriteData  = 32'h0;
          mbx.iWriteData[8] = ($urandom_range(0, 3) != 0);
          mbx.iWriteData[0] = ($urandom_range(0, 19) == 0);
          mbx.iWriteData[1] = ($urandom_range(0, 19) == 0);
          mbx.iWriteData[2] = ($urandom_range(0, 5) == 0);
        end
        2'd3: begin
          mbx.iByteEnable = 4'($urandom_range(0, 15));
          mbx.iWriteData  = ($urandom() & 32'hFFFF_FFE0) | 32'($urandom_range(0, 20));
        end
        default: begin
          mbx.iByteEnable = 4'($urandom_range(0, 15));
          mbx.iWriteData  = $urandom();
        end
      endcase
      mbx.iTxReady = ($urandom_range(0, 9) < 3);
      if (!(mbx.iRxValid && rxQ.size() == DEPTH)) begin
        mbx.iRxValid = ($urandom_range(0, 9) < 6);
        mbx.iRxData  = $urandom();
      end
      iRST = ($urandom_range(0, 599) == 0);
      tick();
    end
    idle();
    iRST = 1'b0;
    mbx.iRxValid = 1'b0;
    mbx.iTxReady = 1'b0;
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
